// File: rtl/rx_pkg.sv
// Shared types and limits for the serial receive controller.
package rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_PARITY = 3'd2,
        S_DONE   = 3'd3,
        S_WAIT   = 3'd4
    } rx_state_t;

    localparam int unsigned RX_MAX_WIDTH = 32;

endpackage

// File: rtl/rx_shift_reg.sv
// Right-shifting capture register; each enabled cycle inserts Sin at the MSB.
module rx_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Shift_En,
    input  logic             Sin,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge Clk) begin
        if (Reset)
            Q <= '0;
        else if (Shift_En)
            Q <= {Sin, Q[WIDTH-1:1]};
    end

endmodule

// File: rtl/shift_rx_ctrl.sv
// Serial-to-parallel receiver: LSB-first capture after Start, Valid/Ack handoff.
// Optional trailing even-parity bit is enabled with the RX_PARITY_EN macro.
module shift_rx_ctrl
    import rx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sin,
    input  logic             Ack,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Valid,
    output logic             Busy,
    output logic             Parity_Err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > RX_MAX_WIDTH) begin : g_width_check
            $error("shift_rx_ctrl: WIDTH out of range");
        end
    endgenerate

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] load_val;
    logic             shift_en;
    logic             cnt_clr;
    logic             last_bit;
    logic             done_entry;

    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
    assign done_entry = (state_d == S_DONE) && (state_q != S_DONE);

    rx_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .Clk      (Clk),
        .Reset    (Reset),
        .Shift_En (shift_en),
        .Sin      (Sin),
        .Q        (sr_q)
    );

    always_ff @(posedge Clk) begin
        if (Reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_SHIFT;
                    cnt_clr = 1'b1;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
`ifdef RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_PARITY: state_d = S_DONE;
            S_DONE: begin
                if (Ack)
                    state_d = Start ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!Start)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter holds at WIDTH-1 after the final shift so it never wraps mid-frame.
    always_ff @(posedge Clk) begin
        if (Reset || cnt_clr)
            cnt_q <= '0;
        else if (shift_en && !last_bit)
            cnt_q <= cnt_q + 1'b1;
    end

`ifdef RX_PARITY_EN
    assign load_val = sr_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            Parity_Err <= 1'b0;
        else if (done_entry)
            Parity_Err <= (^sr_q) ^ Sin;
    end
`else
    // Entry to S_DONE coincides with the last shift, so fold in the live Sin bit.
    assign load_val   = {Sin, sr_q[WIDTH-1:1]};
    assign Parity_Err = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset)
            Data_Out <= '0;
        else if (done_entry)
            Data_Out <= load_val;
    end

    assign Valid = (state_q == S_DONE);
    assign Busy  = (state_q == S_SHIFT) || (state_q == S_PARITY);

endmodule

// File: tb/tb_shift_rx_ctrl.sv
// Directed-vector bench for shift_rx_ctrl (WIDTH=8); parity checks follow RX_PARITY_EN.
module tb_shift_rx_ctrl;

    localparam int unsigned W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic         Sin = 1'b0;
    logic         Ack = 1'b0;
    logic [W-1:0] Data_Out;
    logic         Valid;
    logic         Busy;
    logic         Parity_Err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       glitch;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t vecs [7];

    shift_rx_ctrl #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Sin        (Sin),
        .Ack        (Ack),
        .Data_Out   (Data_Out),
        .Valid      (Valid),
        .Busy       (Busy),
        .Parity_Err (Parity_Err)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs a frame from a Start sample up to the point where Valid should be high.
    task automatic rx_frame(input logic [7:0] data, input logic pbit, input logic glitch,
                            input logic [7:0] exp_data, input logic exp_perr);
        Start = 1'b1;
        tick();
        chk("busy_after_start", Busy, 1);
        for (int i = 0; i < 8; i++) begin
            Sin   = data[i];
            Start = (glitch && i < 7) ? logic'(i % 2) : 1'b0;
            tick();
            if (i < 7) begin
                chk("busy_mid", Busy, 1);
                chk("valid_mid", Valid, 0);
            end
        end
`ifdef RX_PARITY_EN
        chk("valid_before_parity", Valid, 0);
        chk("busy_parity", Busy, 1);
        Sin = pbit;
        tick();
        chk("parity_err", Parity_Err, exp_perr);
`endif
        chk("valid_done", Valid, 1);
        chk("busy_done", Busy, 0);
        chk("data_out", Data_Out, exp_data);
        Sin = 1'b0;
    endtask

    task automatic ack_idle(input logic [7:0] exp_data);
        Ack   = 1'b1;
        Start = 1'b0;
        tick();
        Ack = 1'b0;
        chk("valid_after_ack", Valid, 0);
        chk("busy_after_ack", Busy, 0);
        chk("data_hold", Data_Out, exp_data);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, pbit: 1'b0, glitch: 1'b0, exp_data: 8'hA5, exp_perr: 1'b0};
        vecs[1] = '{data: 8'hA5, pbit: 1'b1, glitch: 1'b0, exp_data: 8'hA5, exp_perr: 1'b1};
        vecs[2] = '{data: 8'hFF, pbit: 1'b0, glitch: 1'b0, exp_data: 8'hFF, exp_perr: 1'b0};
        vecs[3] = '{data: 8'h00, pbit: 1'b1, glitch: 1'b0, exp_data: 8'h00, exp_perr: 1'b1};
        vecs[4] = '{data: 8'h3C, pbit: 1'b1, glitch: 1'b0, exp_data: 8'h3C, exp_perr: 1'b1};
        vecs[5] = '{data: 8'h81, pbit: 1'b0, glitch: 1'b1, exp_data: 8'h81, exp_perr: 1'b0};
        vecs[6] = '{data: 8'h01, pbit: 1'b0, glitch: 1'b1, exp_data: 8'h01, exp_perr: 1'b1};

        tick();
        tick();
        Reset = 1'b0;
        chk("rst_valid", Valid, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_data", Data_Out, 0);
        chk("rst_perr", Parity_Err, 0);

        // Idle with Start low must not begin a frame.
        tick();
        tick();
        chk("idle_busy", Busy, 0);

        // Vector table; Ack with Start low returns to idle and the next frame follows at once.
        for (int v = 0; v < 7; v++) begin
            rx_frame(vecs[v].data, vecs[v].pbit, vecs[v].glitch, vecs[v].exp_data, vecs[v].exp_perr);
            ack_idle(vecs[v].exp_data);
        end

        // Handshake: Valid held without Ack, then Ack with Start high parks in S_WAIT.
        rx_frame(8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("valid_hold", Valid, 1);
        end
        Ack   = 1'b1;
        Start = 1'b1;
        tick();
        Ack = 1'b0;
        chk("wait_valid", Valid, 0);
        Sin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wait_busy", Busy, 0);
            chk("wait_valid_low", Valid, 0);
        end
        Start = 1'b0;
        tick();
        chk("wait_data", Data_Out, 32'h5A);
        Start = 1'b1;
        tick();
        chk("rearm_busy", Busy, 1);
        Start = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rearm_rst_data", Data_Out, 0);

        // Reset sampled at E4 of a frame already in progress.
        rx_frame(8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0);
        ack_idle(8'hC3);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Sin = 1'b1;
            tick();
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midrst_busy", Busy, 0);
        chk("midrst_valid", Valid, 0);
        chk("midrst_data", Data_Out, 0);
        chk("midrst_perr", Parity_Err, 0);
        rx_frame(8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0);
        ack_idle(8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
